// File: rtl/cpu_if.sv
// Load/run control and observation bus of the cpu core.
// The bench drives it through master and the core through slave.
interface cpu_if;
    logic       ins_write;
    logic       ins_read;
    logic [7:0] instruction_write_data;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic [7:0] alu_result;
    logic [7:0] flag;

    modport master (
        output ins_write, ins_read, instruction_write_data,
        input  pc, instruction, alu_result, flag
    );

    modport slave (
        input  ins_write, ins_read, instruction_write_data,
        output pc, instruction, alu_result, flag
    );
endinterface

// File: rtl/cpu.sv
// 8-bit register CPU: byte-serial program load into a 256x8 memory,
// then two-state fetch/execute over R0-R3 with Z/C/N/V/halted flags.
//
// state | meaning
// EXEC  | instruction = mem[pc]; one-byte ops execute, two-byte ops latch opcode
// IMM   | instruction = latched opcode, mem[pc] supplies the immediate
module cpu (
    input  logic clk,
    input  logic reset,
    cpu_if.slave bus
);
    typedef enum logic {EXEC, IMM} state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] mem [256];
    logic [7:0] regs [4];
    logic [7:0] pc, opcode_q, alu_q, flag_q;

    logic [7:0] ins, imm, rd_v, rs_v, res, next_pc;
    logic [8:0] tmp;
    logic       c_out, v_out, wr, upd_res, set_halt, latch, cond_ok;

    assign bus.pc          = pc;
    assign bus.instruction = ins;
    assign bus.alu_result  = alu_q;
    assign bus.flag        = flag_q;

    always_comb begin
        ins        = (state == IMM) ? opcode_q : mem[pc];
        imm        = mem[pc];
        rd_v       = regs[ins[3:2]];
        rs_v       = regs[ins[1:0]];
        tmp        = 9'd0;
        res        = 8'h00;
        c_out      = 1'b0;
        v_out      = 1'b0;
        wr         = 1'b0;
        upd_res    = 1'b0;
        set_halt   = 1'b0;
        latch      = 1'b0;
        cond_ok    = 1'b0;
        next_pc    = pc + 8'd1;
        next_state = EXEC;

        case (ins[3:2])
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = flag_q[0];
            2'b10:   cond_ok = flag_q[1];
            default: cond_ok = !flag_q[0];
        endcase

        if (state == IMM) begin
            case (ins[5:4])
                2'b00: begin
                    res     = imm;
                    wr      = 1'b1;
                    upd_res = 1'b1;
                end
                2'b01: begin
                    tmp     = {1'b0, rd_v} + {1'b0, imm};
                    res     = tmp[7:0];
                    c_out   = tmp[8];
                    v_out   = (rd_v[7] == imm[7]) && (res[7] != rd_v[7]);
                    wr      = 1'b1;
                    upd_res = 1'b1;
                end
                default: begin
                    if (cond_ok)
                        next_pc = imm;
                end
            endcase
        end else begin
            case (ins[7:6])
                2'b00: begin
                    wr      = 1'b1;
                    upd_res = 1'b1;
                    case (ins[5:4])
                        2'b00: begin
                            tmp   = {1'b0, rd_v} + {1'b0, rs_v};
                            res   = tmp[7:0];
                            c_out = tmp[8];
                            v_out = (rd_v[7] == rs_v[7]) && (res[7] != rd_v[7]);
                        end
                        2'b01: begin
                            tmp   = {1'b0, rd_v} - {1'b0, rs_v};
                            res   = tmp[7:0];
                            c_out = tmp[8];
                            v_out = (rd_v[7] != rs_v[7]) && (res[7] != rd_v[7]);
                        end
                        2'b10:   res = rd_v & rs_v;
                        default: res = rd_v | rs_v;
                    endcase
                end
                2'b01: begin
                    // CMP shares the subtract path but never writes Rd
                    upd_res = 1'b1;
                    wr      = (ins[5:4] != 2'b11);
                    case (ins[5:4])
                        2'b00:   res = rd_v ^ rs_v;
                        2'b01:   res = rs_v;
                        2'b10:   res = ~rs_v;
                        default: begin
                            tmp   = {1'b0, rd_v} - {1'b0, rs_v};
                            res   = tmp[7:0];
                            c_out = tmp[8];
                            v_out = (rd_v[7] != rs_v[7]) && (res[7] != rd_v[7]);
                        end
                    endcase
                end
                2'b10: begin
                    wr      = 1'b1;
                    upd_res = 1'b1;
                    case (ins[5:4])
                        2'b00: begin
                            res   = {rd_v[6:0], 1'b0};
                            c_out = rd_v[7];
                        end
                        2'b01: begin
                            res   = {1'b0, rd_v[7:1]};
                            c_out = rd_v[0];
                        end
                        2'b10: begin
                            tmp   = {1'b0, rd_v} + 9'd1;
                            res   = tmp[7:0];
                            c_out = tmp[8];
                            v_out = (res == 8'h80);
                        end
                        default: begin
                            tmp   = {1'b0, rd_v} - 9'd1;
                            res   = tmp[7:0];
                            c_out = tmp[8];
                            v_out = (res == 8'h7F);
                        end
                    endcase
                end
                default: begin
                    if (ins[5:4] == 2'b11) begin
                        set_halt = 1'b1;
                        next_pc  = pc;
                    end else begin
                        latch      = 1'b1;
                        next_state = IMM;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EXEC;
            pc       <= 8'h00;
            opcode_q <= 8'h00;
            alu_q    <= 8'h00;
            flag_q   <= 8'h00;
            for (int i = 0; i < 4; i++)
                regs[i] <= 8'h00;
        end else if (bus.ins_write) begin
            pc    <= pc + 8'd1;
            state <= EXEC;
        end else if (bus.ins_read && !flag_q[4]) begin
            if (wr)
                regs[ins[3:2]] <= res;
            if (upd_res) begin
                alu_q  <= res;
                flag_q <= {4'b0000, v_out, res[7], c_out, (res == 8'h00)};
            end
            if (set_halt)
                flag_q[4] <= 1'b1;
            if (latch)
                opcode_q <= ins;
            pc    <= next_pc;
            state <= next_state;
        end
    end

    // Program memory is never reset so a reset pulse can rewind pc over a loaded program
    always_ff @(posedge clk) begin
        if (bus.ins_write)
            mem[pc] <= bus.instruction_write_data;
    end
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed program scenarios plus random programs
// compared instruction-by-instruction against an ISA-level reference model.
module tb_cpu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    cpu_if bus();

    cpu u_dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_r [4];
    logic [7:0] m_pc, m_alu, m_flag;

    function automatic int sx(input logic [7:0] x);
        return x[7] ? int'(x) - 256 : int'(x);
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_alu = 8'h00; m_flag = 8'h00;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    endtask

    // Executes one whole instruction on the model; len is its cycle count
    task automatic model_instr(output int len);
        logic [7:0] op, a, b, imm, r8;
        logic [1:0] d, s;
        int r, sr;
        bit c, v, wr, upd, take;
        op = m_mem[m_pc];
        imm = m_mem[m_pc + 8'd1];
        len = 1;
        if (m_flag[4]) return;
        d = op[3:2]; s = op[1:0]; a = m_r[d]; b = m_r[s];
        r = 0; sr = 0; c = 0; v = 0; wr = 1; upd = 1; take = 0;
        case (op[7:4])
            4'h0: begin r = int'(a) + int'(b); sr = sx(a) + sx(b); c = (r > 255); v = (sr > 127) || (sr < -128); end
            4'h1, 4'h7: begin
                r = int'(a) - int'(b); sr = sx(a) - sx(b); c = (r < 0); v = (sr > 127) || (sr < -128);
                wr = (op[7:4] == 4'h1);
            end
            4'h2: r = int'(a & b);
            4'h3: r = int'(a | b);
            4'h4: r = int'(a ^ b);
            4'h5: r = int'(b);
            4'h6: r = 255 - int'(b);
            4'h8: begin r = int'(a) * 2; c = (int'(a) >= 128); end
            4'h9: begin r = int'(a) / 2; c = (int'(a) % 2 == 1); end
            4'hA: begin r = int'(a) + 1; c = (r > 255); v = (sx(a) == 127); end
            4'hB: begin r = int'(a) - 1; c = (r < 0); v = (sx(a) == -128); end
            4'hC: begin r = int'(imm); len = 2; end
            4'hD: begin r = int'(a) + int'(imm); sr = sx(a) + sx(imm); c = (r > 255); v = (sr > 127) || (sr < -128); len = 2; end
            4'hE: begin
                len = 2; wr = 0; upd = 0;
                case (d)
                    2'd0: take = 1;
                    2'd1: take = m_flag[0];
                    2'd2: take = m_flag[1];
                    default: take = !m_flag[0];
                endcase
            end
            default: begin wr = 0; upd = 0; m_flag[4] = 1'b1; end
        endcase
        r8 = 8'(r);
        if (wr) m_r[d] = r8;
        if (upd) begin
            m_alu = r8;
            m_flag = {4'b0000, v, r8[7], c, (r8 == 8'h00)};
        end
        if (op[7:4] == 4'hE) m_pc = take ? imm : m_pc + 8'd2;
        else if (op[7:4] != 4'hF) m_pc = m_pc + 8'(len);
    endtask

    task automatic apply_reset(input bit chk_ins);
        reset = 1'b1;
        #2;
        model_reset();
        vectors += 3;
        if (bus.pc !== 8'h00) begin miscompares++; $display("FAIL reset_pc: got %h expected 00", bus.pc); end
        if (bus.alu_result !== 8'h00) begin miscompares++; $display("FAIL reset_alu: got %h expected 00", bus.alu_result); end
        if (bus.flag !== 8'h00) begin miscompares++; $display("FAIL reset_flag: got %h expected 00", bus.flag); end
        if (chk_ins) begin
            vectors++;
            if (bus.instruction !== m_mem[0]) begin miscompares++; $display("FAIL reset_ins: got %h expected %h", bus.instruction, m_mem[0]); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] bytes[$], input bit with_read);
        foreach (bytes[i]) begin
            bus.ins_write = 1'b1;
            bus.ins_read = with_read;
            bus.instruction_write_data = bytes[i];
            @(posedge clk); #1;
            m_mem[m_pc] = bytes[i];
            m_pc = m_pc + 8'd1;
            vectors += 3;
            if (bus.pc !== m_pc) begin miscompares++; $display("FAIL load_pc: got %h expected %h", bus.pc, m_pc); end
            if (bus.alu_result !== m_alu) begin miscompares++; $display("FAIL load_alu: got %h expected %h", bus.alu_result, m_alu); end
            if (bus.flag !== m_flag) begin miscompares++; $display("FAIL load_flag: got %h expected %h", bus.flag, m_flag); end
        end
        bus.ins_write = 1'b0;
        bus.ins_read = 1'b0;
    endtask

    task automatic run_instr(input bit gaps);
        logic [7:0] op0, pc0, pc_mid;
        int len;
        op0 = m_mem[m_pc];
        pc0 = m_pc;
        vectors++;
        if (bus.instruction !== op0) begin miscompares++; $display("FAIL fetch_ins: got %h expected %h", bus.instruction, op0); end
        model_instr(len);
        for (int k = 0; k < len; k++) begin
            pc_mid = (k == 0) ? pc0 : pc0 + 8'd1;
            if (gaps && $urandom_range(3) == 0) begin
                bus.ins_read = 1'b0;
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
                vectors += 2;
                if (bus.pc !== pc_mid) begin miscompares++; $display("FAIL idle_pc: got %h expected %h", bus.pc, pc_mid); end
                if (bus.instruction !== op0) begin miscompares++; $display("FAIL idle_ins: got %h expected %h", bus.instruction, op0); end
            end
            bus.ins_read = 1'b1;
            @(posedge clk); #1;
            bus.ins_read = 1'b0;
            if (k == 0 && len == 2) begin
                vectors += 2;
                if (bus.pc !== pc0 + 8'd1) begin miscompares++; $display("FAIL imm_pc: got %h expected %h", bus.pc, pc0 + 8'd1); end
                if (bus.instruction !== op0) begin miscompares++; $display("FAIL imm_ins: got %h expected %h", bus.instruction, op0); end
            end
        end
        vectors += 3;
        if (bus.pc !== m_pc) begin miscompares++; $display("FAIL exec_pc: op %h got %h expected %h", op0, bus.pc, m_pc); end
        if (bus.alu_result !== m_alu) begin miscompares++; $display("FAIL exec_alu: op %h got %h expected %h", op0, bus.alu_result, m_alu); end
        if (bus.flag !== m_flag) begin miscompares++; $display("FAIL exec_flag: op %h got %h expected %h", op0, bus.flag, m_flag); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        bus.ins_write = 1'b0;
        bus.ins_read = 1'b0;
        bus.instruction_write_data = 8'h00;
        apply_reset(0);
    endtask

    task automatic test_ldi_halt();
        logic [7:0] prog[$];
        prog = '{8'hC9, 8'h0A, 8'hFC};
        apply_reset(0); load_bytes(prog, 0); apply_reset(1);
        run_instr(0);
        vectors += 3;
        if (bus.alu_result !== 8'h0A) begin miscompares++; $display("FAIL ldi_alu: got %h expected 0a", bus.alu_result); end
        if (bus.flag !== 8'h00) begin miscompares++; $display("FAIL ldi_flag: got %h expected 00", bus.flag); end
        if (bus.pc !== 8'h02) begin miscompares++; $display("FAIL ldi_pc: got %h expected 02", bus.pc); end
        repeat (4) run_instr(0);
        vectors += 2;
        if (bus.flag !== 8'h10) begin miscompares++; $display("FAIL halt_flag: got %h expected 10", bus.flag); end
        if (bus.pc !== 8'h02) begin miscompares++; $display("FAIL halt_pc: got %h expected 02", bus.pc); end
    endtask

    task automatic test_add_carry();
        logic [7:0] prog[$];
        prog = '{8'hC0, 8'hFF, 8'hC4, 8'h01, 8'h01};
        apply_reset(0); load_bytes(prog, 0); apply_reset(1);
        repeat (3) run_instr(0);
        vectors += 2;
        if (bus.alu_result !== 8'h00) begin miscompares++; $display("FAIL add_alu: got %h expected 00", bus.alu_result); end
        if (bus.flag !== 8'h03) begin miscompares++; $display("FAIL add_flag: got %h expected 03", bus.flag); end
    endtask

    task automatic test_jmp();
        logic [7:0] prog[$];
        prog = '{8'hC0, 8'h05, 8'h70, 8'hE4, 8'h00};
        apply_reset(0); load_bytes(prog, 0); apply_reset(1);
        for (int loop = 0; loop < 2; loop++) begin
            repeat (3) run_instr(1);
            vectors += 2;
            if (bus.pc !== 8'h00) begin miscompares++; $display("FAIL jz_pc: got %h expected 00", bus.pc); end
            if (bus.flag !== 8'h01) begin miscompares++; $display("FAIL jz_flag: got %h expected 01", bus.flag); end
        end
        prog = '{8'hC0, 8'h05, 8'h70, 8'hEC, 8'h00};
        apply_reset(0); load_bytes(prog, 0); apply_reset(1);
        repeat (3) run_instr(0);
        vectors++;
        if (bus.pc !== 8'h05) begin miscompares++; $display("FAIL jnz_pc: got %h expected 05", bus.pc); end
    endtask

    task automatic test_shift();
        logic [7:0] prog[$];
        prog = '{8'hCC, 8'h81, 8'h9C, 8'h8C};
        apply_reset(0); load_bytes(prog, 0); apply_reset(1);
        repeat (2) run_instr(0);
        vectors += 2;
        if (bus.alu_result !== 8'h40) begin miscompares++; $display("FAIL shr_alu: got %h expected 40", bus.alu_result); end
        if (bus.flag !== 8'h02) begin miscompares++; $display("FAIL shr_flag: got %h expected 02", bus.flag); end
        run_instr(0);
        vectors += 2;
        if (bus.alu_result !== 8'h80) begin miscompares++; $display("FAIL shl_alu: got %h expected 80", bus.alu_result); end
        if (bus.flag !== 8'h04) begin miscompares++; $display("FAIL shl_flag: got %h expected 04", bus.flag); end
    endtask

    task automatic test_reset_mid_imm();
        logic [7:0] prog[$];
        prog = '{8'hC0, 8'h07, 8'hC5, 8'h33};
        apply_reset(0); load_bytes(prog, 0); apply_reset(1);
        run_instr(0);
        bus.ins_read = 1'b1;
        @(posedge clk); #1;
        bus.ins_read = 1'b0;
        vectors++;
        if (bus.pc !== 8'h03) begin miscompares++; $display("FAIL mid_imm_pc: got %h expected 03", bus.pc); end
        apply_reset(1);
        repeat (2) run_instr(0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors += 4;
            if (bus.pc !== 8'h04) begin miscompares++; $display("FAIL hold_pc: got %h expected 04", bus.pc); end
            if (bus.alu_result !== 8'h33) begin miscompares++; $display("FAIL hold_alu: got %h expected 33", bus.alu_result); end
            if (bus.flag !== 8'h00) begin miscompares++; $display("FAIL hold_flag: got %h expected 00", bus.flag); end
            if (bus.instruction !== m_mem[4]) begin miscompares++; $display("FAIL hold_ins: got %h expected %h", bus.instruction, m_mem[4]); end
        end
    endtask

    task automatic test_write_priority();
        logic [7:0] prog[$];
        logic [7:0] wbytes[$];
        prog = {};
        for (int i = 0; i < 19; i++) prog.push_back(8'h00);
        prog[0] = 8'hC0; prog[1] = 8'h80; prog[2] = 8'hE0; prog[3] = 8'h10;
        prog[18] = 8'hA0;
        apply_reset(0); load_bytes(prog, 0); apply_reset(1);
        repeat (2) run_instr(0);
        wbytes = '{8'($urandom), 8'($urandom)};
        load_bytes(wbytes, 1);
        vectors += 3;
        if (bus.pc !== 8'h12) begin miscompares++; $display("FAIL wr_pc: got %h expected 12", bus.pc); end
        if (bus.alu_result !== 8'h80) begin miscompares++; $display("FAIL wr_alu: got %h expected 80", bus.alu_result); end
        if (bus.flag !== 8'h04) begin miscompares++; $display("FAIL wr_flag: got %h expected 04", bus.flag); end
        run_instr(0);
        vectors++;
        if (bus.alu_result !== 8'h81) begin miscompares++; $display("FAIL wr_inc_alu: got %h expected 81", bus.alu_result); end
    endtask

    task automatic test_random();
        logic [7:0] prog[$];
        logic [7:0] b;
        for (int round = 0; round < 4; round++) begin
            apply_reset(1);
            prog = {};
            for (int i = 0; i < 256; i++) begin
                b = 8'($urandom);
                if (b[7:4] == 4'hF && $urandom_range(7) != 0) b = 8'($urandom_range(8'hEF));
                prog.push_back(b);
            end
            load_bytes(prog, 1'($urandom_range(1)));
            for (int n = 0; n < 120; n++) run_instr(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ldi_halt();
        test_add_carry();
        test_jmp();
        test_shift();
        test_reset_mid_imm();
        test_write_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Minimal 8-bit accumulator/register CPU with an internal 256x8 instruction memory, four general registers R0-R3, an ALU and a flag register.
- The same block loads its program through a byte-serial write port, then executes it when reading is enabled.
- It is the top-level processor core; its status outputs (pc, current instruction, last ALU result, flags) are exported for observation.

Parameters:
- None. Data width is fixed at 8, memory depth at 256, and there are 4 registers.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ins_write  input  1  load mode; write instruction_write_data into memory
- ins_read  input  1  run mode; fetch and execute
- instruction_write_data  input  8  program byte to store
- pc  output  8  program counter, also the load address
- instruction  output  8  opcode being executed
- alu_result  output  8  last value produced by the ALU or a load
- flag  output  8  status flags

Behaviour:
- Reset (async):
  - Clears pc, R0-R3, alu_result and flag to 0; state goes to EXEC.
  - Instruction memory is NOT cleared. It powers up as all zeros.
- Load mode (ins_write=1):
  - On each rising edge, mem[pc] <= instruction_write_data and pc <= pc+1. No execution occurs; state is forced to EXEC.
  - ins_write has priority over ins_read.
  - Usage: load the program, then pulse reset to rewind pc to 0.
- Idle (ins_write=0, ins_read=0): all state holds.
- Run mode (ins_read=1, ins_write=0), two states:
  - EXEC: instruction = mem[pc] (combinational).
    - One-byte instructions execute at the edge and then pc <= pc+1.
    - Two-byte instructions latch the opcode, set pc <= pc+1 and move to IMM.
  - IMM: instruction = latched opcode and imm = mem[pc].
    - Execute, then pc <= pc+1 (or the jump target) and return to EXEC.
    - Two-byte latency is therefore 2 cycles.
- pc wraps 255 -> 0.
- Encoding [7:6] class, [5:4] op, [3:2] d, [1:0] s:
  - Class 00, Rd <= Rd op Rs: ADD, SUB, AND, OR.
  - Class 01: XOR (Rd^Rs), MOV (Rd <= Rs), NOT (Rd <= ~Rs), CMP (Rd-Rs, flags only, no write).
  - Class 10, unary on Rd, s ignored: SHL, SHR (logical), INC, DEC.
  - Class 11, two-byte forms:
    - op00 LDI: Rd <= imm.
    - op01 ADDI: Rd <= Rd+imm.
    - op10 JMP: [3:2] is the condition (00 always, 01 Z=1, 10 C=1, 11 Z=0). If true pc <= imm, else pc+1.
    - op11 HALT: one-byte; sets the halted flag; pc holds until reset.
- alu_result:
  - Updated with the 8-bit value written to Rd.
  - For CMP, updated with the difference.
  - Unchanged by JMP and HALT.
- flag bits:
  - [0] Z: result==0.
  - [1] C: ADD/ADDI/INC carry-out; SUB/CMP/DEC borrow; SHL bit7 out; SHR bit0 out.
  - [2] N: result[7].
  - [3] V: signed overflow for add/sub forms.
  - [4] halted.
  - [7:5] always 0.
- Flag update rules:
  - Logic ops, MOV and LDI update Z and N and clear C and V.
  - JMP leaves flags unchanged.
- Arithmetic is mod 256.

Test Plan:
- Load at pc 0..2 = 0xC9, 0x0A, 0xFC, pulse reset, run:
  - Cycle 1: instruction = 0xC9, pc 0 -> 1.
  - Cycle 2: R2 = 10, alu_result = 0x0A, flag = 0x00, pc = 2.
  - Then HALT: flag[4] = 1 and pc stays at 2.
- Load LDI R0,0xFF; LDI R1,0x01; ADD R0,R1 (0x01) -> alu_result = 0x00, flag = Z|C = 0x03.
- Load LDI R0,5; CMP R0,R0 (0x70); JMP Z,0x00 (0xE4,0x00) -> pc returns to 0 and the sequence repeats. JMP NZ falls through instead.
- Load LDI R3,0x81; SHR R3 (0x9C) -> alu_result = 0x40, C = 1. Then SHL R3 (0x8C) -> 0x80, N = 1.
- Assert reset mid-IMM (after a 0xC5 fetch) -> pc, registers, alu_result and flag go to 0 immediately and state is EXEC. ins_read=0 for 3 cycles -> pc and outputs hold.
- Assert ins_write=1 and ins_read=1 together -> the write occurs, pc increments, and no register or flag changes.
